// File: rtl/clock_time_core.sv
// Time-of-day core: BCD hh:mm:ss counter driven by a 1 Hz tick, with hour/minute
// set modes and an alarm that rings for RING_SECS ticks.
`timescale 1ns/1ps
module clock_time_core #(
  parameter int unsigned RING_SECS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] set_mode,
  input  logic       inc,
  input  logic       alarm_en,
  input  logic       alarm_off,
  input  logic [4:0] alarm_hr,
  input  logic [5:0] alarm_min,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       min_tick,
  output logic       ring
);

  localparam int unsigned CNT_W = (RING_SECS < 1) ? 1 : $clog2(RING_SECS + 1);
  localparam logic [7:0]  SEC_LAST = 8'h59;
  localparam logic [7:0]  MIN_LAST = 8'h59;
  localparam logic [7:0]  HR_LAST  = 8'h23;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ring_cnt;

  logic [7:0] run_sec;
  logic [7:0] run_min;
  logic [7:0] run_hr;
  logic       sec_wrap;
  logic       alarm_match;

  // Two-digit BCD increment with wrap to 00 after the field's last value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  // Time that a RUN-mode tick would produce, including minute/hour carries.
  always_comb begin
    sec_wrap = (sec_bcd == SEC_LAST);
    run_sec  = bcd_inc(sec_bcd, SEC_LAST);
    run_min  = min_bcd;
    run_hr   = hr_bcd;
    if (sec_wrap) begin
      run_min = bcd_inc(min_bcd, MIN_LAST);
      if (min_bcd == MIN_LAST)
        run_hr = bcd_inc(hr_bcd, HR_LAST);
    end
  end

  // Alarm operands >23 / >59 can never equal a legal time, so no range check is needed.
  always_comb begin
    alarm_match = (run_sec == 8'h00) &&
                  (bcd_to_bin(run_hr)  == 7'(alarm_hr)) &&
                  (bcd_to_bin(run_min) == 7'(alarm_min));
  end

  // Mode register follows set_mode directly; 11 behaves as run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (set_mode)
        2'b01:   state <= SET_HR;
        2'b10:   state <= SET_MIN;
        default: state <= RUN;
      endcase
    end
  end

  // Time registers and minute pulse; set modes freeze time and take inc instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hr_bcd   <= 8'h00;
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
      min_tick <= 1'b0;
    end else begin
      min_tick <= 1'b0;
      case (state)
        RUN: begin
          if (tick) begin
            sec_bcd  <= run_sec;
            min_bcd  <= run_min;
            hr_bcd   <= run_hr;
            min_tick <= sec_wrap;
          end
        end
        SET_HR: begin
          if (inc)
            hr_bcd <= bcd_inc(hr_bcd, HR_LAST);
        end
        SET_MIN: begin
          if (inc) begin
            min_bcd <= bcd_inc(min_bcd, MIN_LAST);
            sec_bcd <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  // Alarm: any cancel source wins over a trigger; a trigger reloads the duration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if ((state != RUN) || alarm_off || !alarm_en) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if (tick && alarm_match) begin
      ring     <= (RING_SECS != 0);
      ring_cnt <= CNT_W'(RING_SECS);
    end else if (ring && tick) begin
      ring_cnt <= ring_cnt - CNT_W'(1);
      if (ring_cnt <= CNT_W'(1))
        ring <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core: counting, carries, set modes, alarm and reset.
`timescale 1ns/1ps
module tb_clock_time_core;

  localparam int unsigned RING = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] set_mode = 2'b00;
  logic       inc = 1'b0;
  logic       alarm_en = 1'b0;
  logic       alarm_off = 1'b0;
  logic [4:0] alarm_hr = 5'd0;
  logic [5:0] alarm_min = 6'd0;
  logic [7:0] hr_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       min_tick;
  logic       ring;

  int total = 0;
  int bad = 0;
  int mt_cnt = 0;

  always #5 clk = ~clk;

  clock_time_core #(.RING_SECS(RING)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .set_mode  (set_mode),
    .inc       (inc),
    .alarm_en  (alarm_en),
    .alarm_off (alarm_off),
    .alarm_hr  (alarm_hr),
    .alarm_min (alarm_min),
    .hr_bcd    (hr_bcd),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .min_tick  (min_tick),
    .ring      (ring)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each pulse is driven on a falling edge and lasts one cycle; on return the
  // registered outputs of the consuming edge are visible.
  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      mt_cnt += int'(min_tick);
    end
  endtask

  task automatic do_inc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) inc = 1'b1;
      @(negedge clk) inc = 1'b0;
    end
  endtask

  task automatic mode(input logic [1:0] m);
    @(negedge clk) set_mode = m;
    @(negedge clk);
  endtask

  initial begin
    #12;
    check("rst_hr", hr_bcd, 8'h00);
    check("rst_min", min_bcd, 8'h00);
    check("rst_sec", sec_bcd, 8'h00);
    check("rst_min_tick", 8'(min_tick), 8'h00);
    check("rst_ring", 8'(ring), 8'h00);
    @(negedge clk) rst = 1'b0;

    // 60 ticks: one minute carry, one min_tick
    mt_cnt = 0;
    do_tick(1);
    check("sec_first", sec_bcd, 8'h01);
    do_tick(9);
    check("sec_bcd_carry", sec_bcd, 8'h10);
    do_tick(50);
    check("min_wrap_sec", sec_bcd, 8'h00);
    check("min_wrap_min", min_bcd, 8'h01);
    check("min_wrap_hr", hr_bcd, 8'h00);
    check("min_tick_count", 8'(mt_cnt), 8'd1);
    @(negedge clk);
    check("min_tick_single", 8'(min_tick), 8'h00);

    // set hours: 25 incs from 00 wraps to 01
    mode(2'b01);
    do_inc(25);
    check("set_hr_25", hr_bcd, 8'h01);
    check("set_hr_min_kept", min_bcd, 8'h01);

    // run to 01:01:37, then hour inc keeps seconds
    mode(2'b00);
    do_tick(37);
    check("run_sec37", sec_bcd, 8'h37);
    mode(2'b01);
    do_inc(1);
    check("set_hr_inc", hr_bcd, 8'h02);
    check("set_hr_sec_kept", sec_bcd, 8'h37);

    // set minutes: ticks frozen, inc clears seconds
    mode(2'b10);
    do_tick(2);
    check("set_tick_ignored", sec_bcd, 8'h37);
    do_inc(1);
    check("set_min_inc", min_bcd, 8'h02);
    check("set_min_sec_clr", sec_bcd, 8'h00);
    @(negedge clk) begin tick = 1'b1; inc = 1'b1; end
    @(negedge clk) begin tick = 1'b0; inc = 1'b0; end
    check("tick_inc_min", min_bcd, 8'h03);
    check("tick_inc_sec", sec_bcd, 8'h00);
    do_inc(57);
    check("set_min_wrap", min_bcd, 8'h00);
    check("set_min_no_carry", hr_bcd, 8'h02);

    // preload 23:59:58 then roll over midnight
    mode(2'b01);
    do_inc(21);
    mode(2'b10);
    do_inc(59);
    mode(2'b00);
    do_tick(58);
    check("pre_hr", hr_bcd, 8'h23);
    check("pre_min", min_bcd, 8'h59);
    check("pre_sec", sec_bcd, 8'h58);
    mt_cnt = 0;
    do_tick(2);
    check("midnight_hr", hr_bcd, 8'h00);
    check("midnight_min", min_bcd, 8'h00);
    check("midnight_sec", sec_bcd, 8'h00);
    check("midnight_min_tick", 8'(mt_cnt), 8'd1);

    // alarm 07:30: set-mode match must not ring
    alarm_hr = 5'd7;
    alarm_min = 6'd30;
    alarm_en = 1'b1;
    mode(2'b01);
    do_inc(7);
    mode(2'b10);
    do_inc(30);
    check("set_match_time", min_bcd, 8'h30);
    check("set_match_no_ring", 8'(ring), 8'h00);
    do_inc(59);
    check("set_min_29", min_bcd, 8'h29);
    mode(2'b00);
    do_tick(59);
    check("pre_alarm_ring", 8'(ring), 8'h00);
    check("pre_alarm_sec", sec_bcd, 8'h59);
    do_tick(1);
    check("alarm_ring", 8'(ring), 8'h01);
    check("alarm_hr_time", hr_bcd, 8'h07);
    check("alarm_min_time", min_bcd, 8'h30);
    do_tick(RING - 1);
    check("ring_hold", 8'(ring), 8'h01);
    do_tick(1);
    check("ring_expire", 8'(ring), 8'h00);

    // alarm_off cancels
    alarm_min = 6'd32;
    do_tick(60);
    check("ring2_on", 8'(ring), 8'h01);
    @(negedge clk) alarm_off = 1'b1;
    @(negedge clk) alarm_off = 1'b0;
    check("alarm_off_clr", 8'(ring), 8'h00);

    // dropping alarm_en cancels
    alarm_min = 6'd33;
    do_tick(60);
    check("ring3_on", 8'(ring), 8'h01);
    @(negedge clk) alarm_en = 1'b0;
    @(negedge clk) alarm_en = 1'b1;
    check("alarm_en_clr", 8'(ring), 8'h00);

    // alarm_off beats a simultaneous trigger
    alarm_min = 6'd34;
    do_tick(59);
    @(negedge clk) begin tick = 1'b1; alarm_off = 1'b1; end
    @(negedge clk) begin tick = 1'b0; alarm_off = 1'b0; end
    check("off_priority_ring", 8'(ring), 8'h00);
    check("off_priority_min", min_bcd, 8'h34);

    // ring at 12:34:56 then asynchronous reset between edges
    mode(2'b01);
    do_inc(5);
    mode(2'b10);
    do_inc(59);
    alarm_hr = 5'd12;
    mode(2'b00);
    do_tick(60);
    check("ring4_on", 8'(ring), 8'h01);
    do_tick(56);
    check("t123456_hr", hr_bcd, 8'h12);
    check("t123456_min", min_bcd, 8'h34);
    check("t123456_sec", sec_bcd, 8'h56);
    check("t123456_ring", 8'(ring), 8'h01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_hr", hr_bcd, 8'h00);
    check("async_rst_min", min_bcd, 8'h00);
    check("async_rst_sec", sec_bcd, 8'h00);
    check("async_rst_ring", 8'(ring), 8'h00);
    check("async_rst_min_tick", 8'(min_tick), 8'h00);
    @(negedge clk) rst = 1'b0;
    do_tick(1);
    check("post_rst_sec", sec_bcd, 8'h01);
    check("post_rst_hr", hr_bcd, 8'h00);
    check("post_rst_ring", 8'(ring), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
